pipe_ctrl: RTL

- Central sequencing controller for the 3-stage (IF / ID / EX) pipelined core.
- Decides each cycle whether the PC advances, whether the IF/ID register loads, flushes or holds, and whether EX receives a bubble.
- Handles taken branches, load-use stalls, the HALT opcode, and a debug halt/step/resume interface.
- Sits beside the PC, instruction memory, IF/ID register and datapath; owns no datapath state.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_det.sv | 30 +++
 rtl/pipe_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
// Purpose: FSM state encodings, the NOP word used for flush/bubble, and the
//          default address/register widths of the core.
package pipe_ctrl_pkg;

  localparam int AW_DEF = 16;
  localparam int RW_DEF = 5;

  // addi x0, x0, 0 : the word IF/ID and EX are loaded with on flush/bubble
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4,
    ST_STEP  = 3'd5
  } pipe_state_e;

endpackage

// File: rtl/pipe_hazard_det.sv
// rtl/pipe_hazard_det.sv - combinational load-use hazard comparator
// Purpose: flags when the ID instruction reads a register that the load in EX
//          has not yet written back.
// Ports:   id_valid_i, id_rs1_i/id_rs2_i, id_use1_i/id_use2_i describe the ID
//          instruction; ex_load_i/ex_rd_i describe EX; hazard_o is the result.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          id_valid_i,
  input  logic [RW-1:0] id_rs1_i,
  input  logic [RW-1:0] id_rs2_i,
  input  logic          id_use1_i,
  input  logic          id_use2_i,
  input  logic          ex_load_i,
  input  logic [RW-1:0] ex_rd_i,
  output logic          hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use2_i & (id_rs2_i == ex_rd_i);

  // x0 is never written, so a load targeting it cannot create a dependency
  assign hazard_o = id_valid_i & ex_load_i & (ex_rd_i != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - IF/ID/EX pipeline sequencing controller
// Purpose: each cycle decides PC advance/redirect, IF/ID load/flush/hold and
//          EX bubble; handles taken branches, load-use stalls, HALT opcode and
//          debug halt/step/resume. Owns no datapath state.
// Ports:   start_i, dbg_*_i       - run control and debug interface
//          id_*_i, ex_*_i         - ID/EX instruction info for hazard and HALT
//          br_taken_i/br_target_i - branch resolution from EX
//          pc_*_o, ifid_*_o, ex_bubble_o - pipeline control (combinational)
//          halted_o, state_o, cyc_cnt_o, stall_cnt_o - status (registered)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int RW        = RW_DEF,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          dbg_halt_i,
  input  logic          dbg_step_i,
  input  logic          dbg_resume_i,
  input  logic          id_valid_i,
  input  logic          id_halt_i,
  input  logic [RW-1:0] id_rs1_i,
  input  logic [RW-1:0] id_rs2_i,
  input  logic          id_use1_i,
  input  logic          id_use2_i,
  input  logic          ex_load_i,
  input  logic [RW-1:0] ex_rd_i,
  input  logic          br_taken_i,
  input  logic [AW-1:0] br_target_i,
  output logic          pc_en_o,
  output logic          pc_load_o,
  output logic [AW-1:0] pc_target_o,
  output logic          ifid_en_o,
  output logic          ifid_flush_o,
  output logic          ex_bubble_o,
  output logic          halted_o,
  output logic [2:0]    state_o,
  output logic [31:0]   cyc_cnt_o,
  output logic [15:0]   stall_cnt_o
);

  localparam logic [3:0] SCNT_INIT = 4'(LOAD_LAT - 1);
  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYC);

  pipe_state_e state_q, state_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [31:0] cyc_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        hazard;
  logic        stall_hit;
  logic        id_is_halt;

  pipe_hazard_det #(.RW(RW)) u_hazard (
    .id_valid_i (id_valid_i),
    .id_rs1_i   (id_rs1_i),
    .id_rs2_i   (id_rs2_i),
    .id_use1_i  (id_use1_i),
    .id_use2_i  (id_use2_i),
    .ex_load_i  (ex_load_i),
    .ex_rd_i    (ex_rd_i),
    .hazard_o   (hazard)
  );

  assign id_is_halt  = id_valid_i & id_halt_i;
  assign pc_target_o = br_target_i;
  assign state_o     = state_q;
  assign cyc_cnt_o   = cyc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    pc_en_o      = 1'b0;
    pc_load_o    = 1'b0;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    ex_bubble_o  = 1'b0;
    halted_o     = 1'b0;
    stall_hit    = 1'b0;
    state_d      = state_q;
    scnt_d       = scnt_q;
    fcnt_d       = fcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        ifid_flush_o = 1'b1;
        ex_bubble_o  = 1'b1;
        if (start_i) state_d = ST_RUN;
      end

      ST_RUN, ST_STALL: begin
        if (br_taken_i) begin
          // redirect wins over everything, including an in-progress stall
          pc_load_o    = 1'b1;
          pc_en_o      = 1'b1;
          ifid_flush_o = 1'b1;
          ex_bubble_o  = 1'b1;
          scnt_d       = '0;
          if (FLUSH_CYC > 0) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_STALL) begin
          ex_bubble_o = 1'b1;
          stall_hit   = 1'b1;
          // the detecting RUN cycle is the first stall cycle, so STALL
          // covers the remaining LOAD_LAT-1 cycles
          if (scnt_q <= 4'd1) begin
            scnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            scnt_d = scnt_q - 4'd1;
          end
        end else if (id_is_halt) begin
          ex_bubble_o = 1'b1;
          state_d     = ST_HALT;
        end else if (hazard) begin
          ex_bubble_o = 1'b1;
          stall_hit   = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_STALL;
            scnt_d  = SCNT_INIT;
          end
        end else if (dbg_halt_i) begin
          ex_bubble_o = 1'b1;
          state_d     = ST_HALT;
        end else begin
          pc_en_o   = 1'b1;
          ifid_en_o = 1'b1;
        end
      end

      ST_FLUSH: begin
        // EX holds a bubble here, so any br_taken is stale and ignored
        pc_en_o      = 1'b1;
        ifid_flush_o = 1'b1;
        ex_bubble_o  = 1'b1;
        if (fcnt_q <= 2'd1) begin
          fcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end

      ST_HALT: begin
        halted_o    = 1'b1;
        ex_bubble_o = 1'b1;
        // a held HALT opcode pins the core here until reset
        if (dbg_resume_i) begin
          if (!id_is_halt) state_d = ST_RUN;
        end else if (dbg_step_i && !id_is_halt) begin
          state_d = ST_STEP;
        end
      end

      ST_STEP: begin
        if (br_taken_i) begin
          pc_load_o    = 1'b1;
          pc_en_o      = 1'b1;
          ifid_flush_o = 1'b1;
          ex_bubble_o  = 1'b1;
        end else begin
          pc_en_o   = 1'b1;
          ifid_en_o = 1'b1;
        end
        state_d = ST_HALT;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scnt_q      <= '0;
      fcnt_q      <= '0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      if (state_q == ST_RUN || state_q == ST_STALL || state_q == ST_FLUSH)
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      // counts every load-use hold cycle, including the detecting RUN cycle
      if (stall_hit && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
